// File: rtl/phy_gen_pkg.sv
// Shared types and constants for the PHY traffic generator: data modes, FSM states,
// latched sequence configuration and LFSR feedback taps.
package phy_gen_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned SYNC_W = 4;

    localparam logic [7:0]  BC_BYTE_DEFAULT = 8'hBC;
    // x^32 + x^22 + x^2 + x + 1 as a Fibonacci tap mask (bits 31, 21, 1, 0)
    localparam logic [31:0] LFSR_TAPS_32    = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_MEM   = 2'd0,
        MODE_INC   = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_GAP,
        ST_FIN
    } state_e;

    typedef struct packed {
        mode_e             mode;
        logic [LEN_W-1:0]  length;
        logic [GAP_W-1:0]  gap;
    } seq_cfg_t;

    // Maximal-length tap masks for common lane widths; other widths fall back to the 32-bit mask.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            64:      return 64'hD800_0000_0000_0000;
            default: return {32'd0, LFSR_TAPS_32};
        endcase
    endfunction

endpackage

// File: rtl/phy_traffic_gen_if.sv
// Transmit-side bus between the traffic generator and the PHY input.
interface phy_traffic_gen_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1
);
    logic                     active;
    logic                     valid;
    logic                     ready;
    logic [LANES*WIDTH-1:0]   data_out;

    modport master (output active, output valid, output data_out, input ready);
    modport slave  (input active, input valid, input data_out, output ready);
endinterface

// File: rtl/phy_lfsr.sv
// Per-lane Fibonacci LFSR: loadable, advances one step on request, never holds zero after load.
module phy_lfsr
    import phy_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_32)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_c
);

    assign next_c = {state[WIDTH-2:0], ^(state & TAPS)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WIDTH'(1);
        end else if (load) begin
            state <= (load_value == '0) ? WIDTH'(1) : load_value;
        end else if (advance) begin
            state <= next_c;
        end
    end

endmodule

// File: rtl/phy_traffic_gen.sv
// Programmable PHY transmit traffic source: start handshake, BC comma run, payload from one
// of four data modes with optional inter-word gaps, honouring downstream backpressure.
module phy_traffic_gen
    import phy_gen_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LANES    = 1,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BC_COUNT = 2,
    parameter logic [7:0]  BC_BYTE  = BC_BYTE_DEFAULT,
    localparam int unsigned DW      = $clog2(DEPTH),
    localparam int unsigned AW      = $clog2(DEPTH) + $clog2(LANES),
    localparam int unsigned DATA_W  = LANES * WIDTH
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  length,
    input  logic [GAP_W-1:0]  gap,
    input  logic [WIDTH-1:0]  seed,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    phy_traffic_gen_if.master tx,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_count
);

    localparam int unsigned       N_BYTES = DATA_W / 8;
    localparam logic [DATA_W-1:0] BC_WORD = {N_BYTES{BC_BYTE}};

    state_e              state;
    seq_cfg_t            cfg;
    logic [WIDTH-1:0]    seed_q;
    logic [SYNC_W-1:0]   sync_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    logic [WIDTH-1:0]    mem [0:(2**AW)-1];

    logic                load_c;
    logic                xfer_c;
    logic                last_c;
    logic [LEN_W-1:0]    idx_c;
    logic [DATA_W-1:0]   word_c;
    logic [WIDTH-1:0]    lfsr_q [LANES];
    logic [WIDTH-1:0]    lfsr_n [LANES];

    // Pattern memory, {word, lane} addressed, writable at any time
    always_ff @(posedge clk_f) begin
        if (cfg_we) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    assign load_c = (state == ST_IDLE) && start;
    assign xfer_c = (state == ST_PAYLOAD) && tx.ready;
    assign last_c = (word_count == LEN_W'(cfg.length - LEN_W'(1)));
    // Index of the word to present next: one ahead when the current word is leaving this edge
    assign idx_c  = xfer_c ? word_count + LEN_W'(1) : word_count;

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        logic [DW-1:0]    widx;
        logic [WIDTH-1:0] lane_c;

        phy_lfsr #(
            .WIDTH (WIDTH),
            .TAPS  (WIDTH'(lfsr_taps(WIDTH)))
        ) u_lfsr (
            .clk        (clk_f),
            .reset      (reset),
            .load       (load_c),
            .advance    (xfer_c),
            .load_value (seed ^ WIDTH'(g)),
            .state      (lfsr_q[g]),
            .next_c     (lfsr_n[g])
        );

        assign widx = idx_c[DW-1:0];

        always_comb begin
            lane_c = seed_q;
            case (cfg.mode)
                MODE_MEM:   lane_c = mem[AW'(32'(widx) * LANES + 32'(g))];
                MODE_INC:   lane_c = seed_q + WIDTH'(idx_c) * WIDTH'(LANES) + WIDTH'(g);
                MODE_PRBS:  lane_c = xfer_c ? lfsr_n[g] : lfsr_q[g];
                MODE_CONST: lane_c = seed_q;
                default:    lane_c = seed_q;
            endcase
        end

        assign word_c[g*WIDTH +: WIDTH] = lane_c;
    end

    // Sequencer with registered bus and status outputs
    always_ff @(posedge clk_f) begin
        if (reset) begin
            state       <= ST_IDLE;
            cfg         <= '0;
            seed_q      <= '0;
            sync_cnt    <= '0;
            gap_cnt     <= '0;
            tx.active   <= 1'b0;
            tx.valid    <= 1'b0;
            tx.data_out <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg.mode    <= mode_e'(mode);
                        cfg.length  <= length;
                        cfg.gap     <= gap;
                        seed_q      <= seed;
                        word_count  <= '0;
                        sync_cnt    <= '0;
                        state       <= ST_SYNC;
                        tx.active   <= 1'b1;
                        tx.valid    <= 1'b0;
                        tx.data_out <= BC_WORD;
                        busy        <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (sync_cnt == SYNC_W'(BC_COUNT - 1)) begin
                        if (cfg.length == '0) begin
                            state       <= ST_FIN;
                            tx.active   <= 1'b0;
                            tx.data_out <= '0;
                            done        <= 1'b1;
                        end else begin
                            state       <= ST_PAYLOAD;
                            tx.valid    <= 1'b1;
                            tx.data_out <= word_c;
                        end
                    end else begin
                        sync_cnt <= sync_cnt + SYNC_W'(1);
                    end
                end
                ST_PAYLOAD: begin
                    if (tx.ready) begin
                        word_count <= word_count + LEN_W'(1);
                        if (last_c) begin
                            state       <= ST_FIN;
                            tx.active   <= 1'b0;
                            tx.valid    <= 1'b0;
                            tx.data_out <= '0;
                            done        <= 1'b1;
                        end else if (cfg.gap != '0) begin
                            state       <= ST_GAP;
                            tx.valid    <= 1'b0;
                            tx.data_out <= '0;
                            gap_cnt     <= cfg.gap - GAP_W'(1);
                        end else begin
                            tx.data_out <= word_c;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state       <= ST_PAYLOAD;
                        tx.valid    <= 1'b1;
                        tx.data_out <= word_c;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_traffic_gen.sv
// Scoreboard bench for phy_traffic_gen with two 32-bit lanes, DEPTH=8, BC_COUNT=2.
module tb_phy_traffic_gen;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BCN   = 2;
    localparam logic [63:0] BC64  = 64'hBCBC_BCBC_BCBC_BCBC;

    logic        clk_f = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] length;
    logic [3:0]  gap;
    logic [31:0] seed;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;
    logic [15:0] word_count;

    phy_traffic_gen_if #(.WIDTH(WIDTH), .LANES(LANES)) tx ();

    phy_traffic_gen #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .DEPTH    (DEPTH),
        .BC_COUNT (BCN),
        .BC_BYTE  (8'hBC)
    ) dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .length     (length),
        .gap        (gap),
        .seed       (seed),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk_f = ~clk_f;

    typedef struct {
        logic        active;
        logic        valid;
        logic        rdy;
        logic        busy;
        logic        done;
        logic [63:0] data;
        logic [15:0] wc;
    } snap_t;

    snap_t       snaps[$];
    logic [63:0] exp_q[$];
    logic [31:0] bmem [16];
    bit          rdy_pat [256];
    int          n_checks;
    int          n_pass;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Reference word for payload index k, lane 0 in the low half
    function automatic logic [63:0] model_word(input logic [1:0] m, input int k, input logic [31:0] sd);
        logic [63:0] w;
        logic [31:0] s;
        w = '0;
        for (int i = 0; i < 2; i++) begin
            case (m)
                2'd0: w[i*32 +: 32] = bmem[(k % 8) * 2 + i];
                2'd1: w[i*32 +: 32] = sd + 32'(k * 2 + i);
                2'd2: begin
                    s = sd ^ 32'(i);
                    if (s == 32'd0) s = 32'd1;
                    for (int j = 0; j < k; j++) s = lfsr_step(s);
                    w[i*32 +: 32] = s;
                end
                default: w[i*32 +: 32] = sd;
            endcase
        end
        return w;
    endfunction

    // Scoreboard: every accepted payload word is checked against the next expected word
    always @(negedge clk_f) begin
        if (reset === 1'b0 && tx.valid === 1'b1 && tx.ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_extra: got %h expected no word", tx.data_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (tx.data_out !== e) $display("FAIL scoreboard_word: got %h expected %h", tx.data_out, e);
                else n_pass++;
            end
        end
    end

    task automatic launch(input logic [1:0] m, input int len, input int g, input logic [31:0] sd);
        for (int k = 0; k < len; k++) exp_q.push_back(model_word(m, k, sd));
        mode   = m;
        length = 16'(len);
        gap    = 4'(g);
        seed   = sd;
        start  = 1'b1;
        @(posedge clk_f); #1;
        start  = 1'b0;
    endtask

    // Records one snapshot per cycle until done is seen or the budget runs out
    task automatic collect(input int max_cyc, output bit timed_out);
        snap_t s;
        snaps.delete();
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            tx.ready = (c < 256) ? rdy_pat[c] : 1'b1;
            @(negedge clk_f);
            s.active = tx.active;
            s.valid  = tx.valid;
            s.rdy    = tx.ready;
            s.busy   = busy;
            s.done   = done;
            s.data   = tx.data_out;
            s.wc     = word_count;
            snaps.push_back(s);
            @(posedge clk_f); #1;
            if (s.done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        tx.ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_f);
        n_checks++;
        if ({tx.active, tx.valid, busy, done} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {tx.active, tx.valid, busy, done});
        else n_pass++;
        n_checks++;
        if (tx.data_out !== 64'd0) $display("FAIL reset_data: got %h expected 0", tx.data_out);
        else n_pass++;
        n_checks++;
        if (word_count !== 16'd0) $display("FAIL reset_wc: got %0d expected 0", word_count);
        else n_pass++;
        @(posedge clk_f); #1;
        reset = 1'b0;
        @(negedge clk_f);
        n_checks++;
        if ({tx.active, busy} !== 2'b00) $display("FAIL idle_after_reset: got %b expected 00", {tx.active, busy});
        else n_pass++;
        @(posedge clk_f); #1;
    endtask

    task automatic test_inc();
        bit to;
        launch(2'd1, 4, 0, 32'hFFFF_EEEE);
        collect(40, to);
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 7) $display("FAIL inc_length: got %0d cycles expected 7", snaps.size());
        else n_pass++;
        if (snaps.size() == 7) begin
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (snaps[c].active !== 1'b1 || snaps[c].valid !== 1'b0 || snaps[c].data !== BC64)
                    $display("FAIL inc_sync%0d: got a=%b v=%b d=%h expected a=1 v=0 d=%h",
                             c, snaps[c].active, snaps[c].valid, snaps[c].data, BC64);
                else n_pass++;
            end
            n_checks++;
            if (snaps[6].active !== 1'b0 || snaps[6].done !== 1'b1 || snaps[6].wc !== 16'd4)
                $display("FAIL inc_fin: got a=%b done=%b wc=%0d expected a=0 done=1 wc=4",
                         snaps[6].active, snaps[6].done, snaps[6].wc);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL inc_left: got %0d words unsent expected 0", exp_q.size());
        else n_pass++;
        @(negedge clk_f);
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL inc_busy_fall: got %b expected 00", {busy, done});
        else n_pass++;
        @(posedge clk_f); #1;
    endtask

    task automatic test_mem();
        bit to;
        logic [31:0] plan [4];
        plan[0] = 32'hADFE_BA01; plan[1] = 32'hFAFA_FA01;
        plan[2] = 32'hAAAA_1234; plan[3] = 32'h1234_5678;
        for (int a = 0; a < 16; a++) begin
            bmem[a]  = (a < 4) ? plan[a] : $urandom;
            cfg_we   = 1'b1;
            cfg_addr = 4'(a);
            cfg_data = bmem[a];
            @(posedge clk_f); #1;
        end
        cfg_we = 1'b0;
        launch(2'd0, 10, 0, 32'd0);
        collect(60, to);
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 13) $display("FAIL mem_length: got %0d cycles expected 13", snaps.size());
        else n_pass++;
        if (snaps.size() == 13) begin
            n_checks++;
            if (snaps[10].data !== {plan[1], plan[0]})
                $display("FAIL mem_wrap8: got %h expected %h", snaps[10].data, {plan[1], plan[0]});
            else n_pass++;
            n_checks++;
            if (snaps[11].data !== {plan[3], plan[2]})
                $display("FAIL mem_wrap9: got %h expected %h", snaps[11].data, {plan[3], plan[2]});
            else n_pass++;
            n_checks++;
            if (snaps[12].wc !== 16'd10) $display("FAIL mem_wc: got %0d expected 10", snaps[12].wc);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL mem_left: got %0d words unsent expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        logic [31:0] sd;
        sd = 32'h1000_0000;
        for (int c = 4; c < 7; c++) rdy_pat[c] = 1'b0;
        launch(2'd1, 6, 0, sd);
        collect(60, to);
        for (int c = 0; c < 256; c++) rdy_pat[c] = 1'b1;
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 12) $display("FAIL bp_length: got %0d cycles expected 12", snaps.size());
        else n_pass++;
        if (snaps.size() == 12) begin
            for (int c = 4; c < 8; c++) begin
                n_checks++;
                if (snaps[c].data !== model_word(2'd1, 2, sd) || snaps[c].wc !== 16'd2 || snaps[c].valid !== 1'b1)
                    $display("FAIL bp_hold%0d: got d=%h wc=%0d expected d=%h wc=2",
                             c, snaps[c].data, snaps[c].wc, model_word(2'd1, 2, sd));
                else n_pass++;
            end
            n_checks++;
            if (snaps[8].data !== model_word(2'd1, 3, sd))
                $display("FAIL bp_resume: got %h expected %h", snaps[8].data, model_word(2'd1, 3, sd));
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_left: got %0d words unsent expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_gap();
        bit to;
        launch(2'd3, 3, 3, 32'hCAFE_F00D);
        collect(60, to);
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 12) $display("FAIL gap_length: got %0d cycles expected 12", snaps.size());
        else n_pass++;
        if (snaps.size() == 12) begin
            for (int c = 3; c < 10; c++) begin
                logic ev;
                ev = (c == 6);
                n_checks++;
                if (snaps[c].active !== 1'b1 || snaps[c].valid !== ev || (!ev && snaps[c].data !== 64'd0))
                    $display("FAIL gap_cycle%0d: got a=%b v=%b d=%h expected a=1 v=%b",
                             c, snaps[c].active, snaps[c].valid, snaps[c].data, ev);
                else n_pass++;
            end
            n_checks++;
            if (snaps[10].valid !== 1'b1 || snaps[11].done !== 1'b1)
                $display("FAIL gap_tail: got v=%b done=%b expected v=1 done=1", snaps[10].valid, snaps[11].done);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL gap_left: got %0d words unsent expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_empty();
        bit to;
        int nvalid;
        launch(2'd1, 0, 0, 32'd5);
        collect(20, to);
        nvalid = 0;
        foreach (snaps[c]) if (snaps[c].valid !== 1'b0) nvalid++;
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 3) $display("FAIL empty_length: got %0d cycles expected 3", snaps.size());
        else n_pass++;
        n_checks++;
        if (nvalid != 0) $display("FAIL empty_valid: got %0d valid cycles expected 0", nvalid);
        else n_pass++;
        if (snaps.size() == 3) begin
            n_checks++;
            if (snaps[2].wc !== 16'd0 || snaps[2].active !== 1'b0)
                $display("FAIL empty_fin: got wc=%0d a=%b expected wc=0 a=0", snaps[2].wc, snaps[2].active);
            else n_pass++;
        end
    endtask

    task automatic test_prbs();
        bit to;
        launch(2'd2, 64, 0, 32'd0);
        collect(200, to);
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 67) $display("FAIL prbs_length: got %0d cycles expected 67", snaps.size());
        else n_pass++;
        if (snaps.size() == 67) begin
            n_checks++;
            if (snaps[2].data !== 64'h0000_0001_0000_0001)
                $display("FAIL prbs_first: got %h expected 0000000100000001", snaps[2].data);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL prbs_left: got %0d words unsent expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        int ndone;
        found = 1'b0;
        launch(2'd1, 20, 0, 32'd0);
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk_f);
            if (tx.valid === 1'b1 && word_count === 16'd5) begin
                found = 1'b1;
                reset = 1'b1;
            end else begin
                @(posedge clk_f); #1;
            end
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL rst_mid_reach: got no word 5 expected word 5 within 40 cycles");
        else n_pass++;
        @(negedge clk_f);
        exp_q.delete();
        n_checks++;
        if ({tx.active, tx.valid, busy, done} !== 4'b0000 || tx.data_out !== 64'd0 || word_count !== 16'd0)
            $display("FAIL rst_mid_outputs: got a=%b v=%b b=%b done=%b d=%h wc=%0d expected all 0",
                     tx.active, tx.valid, busy, done, tx.data_out, word_count);
        else n_pass++;
        @(posedge clk_f); #1;
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_f);
            if (done !== 1'b0 || busy !== 1'b0) ndone++;
            @(posedge clk_f); #1;
        end
        n_checks++;
        if (ndone != 0) $display("FAIL rst_mid_nodone: got %0d done/busy cycles expected 0", ndone);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        bit to;
        launch(2'd1, 4, 0, 32'h0000_0100);
        mode   = 2'd3;
        length = 16'd2;
        gap    = 4'd5;
        seed   = 32'hDEAD_BEEF;
        start  = 1'b1;
        @(posedge clk_f); #1;
        start  = 1'b0;
        collect(40, to);
        n_checks++;
        if (to !== 1'b0 || snaps.size() != 6) $display("FAIL busy_start_length: got %0d cycles expected 6", snaps.size());
        else n_pass++;
        if (snaps.size() == 6) begin
            n_checks++;
            if (snaps[5].wc !== 16'd4 || snaps[0].valid !== 1'b0 || snaps[0].data !== BC64)
                $display("FAIL busy_start_seq: got wc=%0d v0=%b d0=%h expected wc=4 v0=0 d0=%h",
                         snaps[5].wc, snaps[0].valid, snaps[0].data, BC64);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL busy_start_left: got %0d words unsent expected 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        length   = 16'd0;
        gap      = 4'd0;
        seed     = 32'd0;
        cfg_we   = 1'b0;
        cfg_addr = 4'd0;
        cfg_data = 32'd0;
        tx.ready = 1'b1;
        for (int i = 0; i < 16; i++) bmem[i] = 32'd0;
        for (int i = 0; i < 256; i++) rdy_pat[i] = 1'b1;
        repeat (3) @(posedge clk_f);
        #1;
        test_reset();
        test_inc();
        test_mem();
        test_backpressure();
        test_gap();
        test_empty();
        test_prbs();
        test_reset_mid();
        test_busy_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
